// File: rtl/galetron_pkg.sv
// Shared definitions for the boot sequencer: default bus widths and FSM state encoding.
package galetron_pkg;

  localparam int unsigned GT_ADDR_W = 10;
  localparam int unsigned GT_DATA_W = 32;

  typedef enum logic [2:0] {
    StBiosRun,
    StReq,
    StWait,
    StClear,
    StHandoff,
    StSysRun,
    StError
  } state_e;

endpackage

// File: rtl/boot_loader_ctrl_wdog.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module boot_wdog #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: stalls the CPU, copies the program image HD->IM, zeroes DM,
// then resets the PC and hands instruction fetch from BIOS to IM.
module boot_loader_ctrl
  import galetron_pkg::*;
#(
  parameter int unsigned ADDR_W   = GT_ADDR_W,
  parameter int unsigned DATA_W   = GT_DATA_W,
  parameter int unsigned COPY_LEN = 256,
  parameter int unsigned HD_BASE  = 0,
  parameter int unsigned IM_BASE  = 0,
  parameter int unsigned CLR_LEN  = 256,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              hd_rd_en,
  output logic [ADDR_W-1:0] hd_addr,
  input  logic              hd_rd_valid,
  input  logic [DATA_W-1:0] hd_rd_data,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_stall,
  output logic              pc_reset,
  output logic              bios_sel,
  output logic              busy,
  output logic              boot_err
);

  localparam int unsigned CntMax = (COPY_LEN > CLR_LEN) ? COPY_LEN : CLR_LEN;
  localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
  localparam int unsigned WdogW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [CntW-1:0]   CopyLast = CntW'(COPY_LEN - 1);
  localparam logic [CntW-1:0]   ClrLast  = CntW'(CLR_LEN - 1);
  localparam logic [ADDR_W-1:0] HdBase   = ADDR_W'(HD_BASE);
  localparam logic [ADDR_W-1:0] ImBase   = ADDR_W'(IM_BASE);
  // Watchdog reloads with TIMEOUT-1 so WAIT lasts exactly TIMEOUT cycles before expiry.
  localparam logic [WdogW-1:0]  WdogLoad = WdogW'(TIMEOUT - 1);
  localparam state_e            AfterCopy = (CLR_LEN == 0) ? StHandoff : StClear;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] clr_q, clr_d;
  logic            wdog_expired;

  boot_wdog #(
    .W(WdogW)
  ) u_wdog (
    .clock     (clock),
    .reset     (reset),
    .load_i    (state_q == StReq),
    .load_val_i(WdogLoad),
    .dec_i     (state_q == StWait),
    .expired_o (wdog_expired)
  );

  // The IM write must land in the cycle the HD word arrives, so it bypasses the registers.
  assign im_wr_en = (state_q == StWait) && hd_rd_valid && (hd_rd_data != '0);
  assign wr_data  = im_wr_en ? hd_rd_data : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    case (state_q)
      StBiosRun: begin
        if (start) begin
          state_d = StReq;
          cnt_d   = '0;
          clr_d   = '0;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (hd_rd_valid) begin
          if (hd_rd_data == '0) begin
            state_d = AfterCopy;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = (cnt_q == CopyLast) ? AfterCopy : StReq;
          end
        end else if (wdog_expired) begin
          state_d = StError;
        end
      end
      StClear: begin
        if (clr_q == ClrLast) begin
          state_d = StHandoff;
        end else begin
          clr_d = clr_q + CntW'(1);
        end
      end
      StHandoff: state_d = StSysRun;
      default: state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StBiosRun;
      cnt_q      <= '0;
      clr_q      <= '0;
      hd_rd_en   <= 1'b0;
      hd_addr    <= '0;
      im_wr_addr <= '0;
      dm_wr_en   <= 1'b0;
      dm_wr_addr <= '0;
      cpu_stall  <= 1'b0;
      pc_reset   <= 1'b0;
      bios_sel   <= 1'b1;
      busy       <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      hd_rd_en   <= (state_d == StReq);
      hd_addr    <= (state_d == StReq) ? HdBase + ADDR_W'(cnt_d) : '0;
      im_wr_addr <= (state_d == StWait) ? ImBase + ADDR_W'(cnt_d) : '0;
      dm_wr_en   <= (state_d == StClear);
      dm_wr_addr <= (state_d == StClear) ? ADDR_W'(clr_d) : '0;
      cpu_stall  <= state_d inside {StReq, StWait, StClear, StHandoff, StError};
      pc_reset   <= (state_d == StHandoff);
      bios_sel   <= !(state_d inside {StHandoff, StSysRun});
      busy       <= state_d inside {StReq, StWait, StClear, StHandoff};
      boot_err   <= boot_err || (state_d == StError);
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: expected IM/DM writes are queued by the
// stimulus thread and popped by a negedge monitor whenever a write strobe is seen.
module tb_boot_loader_ctrl;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned COPY = 256;
  localparam int unsigned CLR  = 4;
  localparam int unsigned TMO  = 255;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start;
  logic          hd_rd_en, hd_rd_valid;
  logic [AW-1:0] hd_addr, im_wr_addr, dm_wr_addr;
  logic [DW-1:0] hd_rd_data, wr_data;
  logic          im_wr_en, dm_wr_en, cpu_stall, pc_reset, bios_sel, busy, boot_err;

  boot_loader_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .COPY_LEN(COPY),
    .HD_BASE (0),
    .IM_BASE (0),
    .CLR_LEN (CLR),
    .TIMEOUT (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .hd_rd_en   (hd_rd_en),
    .hd_addr    (hd_addr),
    .hd_rd_valid(hd_rd_valid),
    .hd_rd_data (hd_rd_data),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_addr (dm_wr_addr),
    .wr_data    (wr_data),
    .cpu_stall  (cpu_stall),
    .pc_reset   (pc_reset),
    .bios_sel   (bios_sel),
    .busy       (busy),
    .boot_err   (boot_err)
  );

  // HD model: answers a read request one cycle later; inj_v injects stray valids.
  logic [DW-1:0] hd_mem [1024];
  logic          hd_respond = 1'b0;
  logic          hd_v_q = 1'b0;
  logic [DW-1:0] hd_d_q = '0;
  logic          inj_v;
  logic [DW-1:0] inj_d;

  always @(posedge clock) begin
    hd_v_q <= hd_respond && (hd_rd_en === 1'b1);
    hd_d_q <= hd_mem[hd_addr];
  end

  assign hd_rd_valid = hd_v_q | inj_v;
  assign hd_rd_data  = inj_v ? inj_d : hd_d_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           im_q[$];
  logic [AW-1:0] dm_q[$];
  wr_t           exp_w;
  logic [AW-1:0] exp_a;
  int            im_cnt = 0;
  int            dm_cnt = 0;
  int            pc_cnt = 0;
  bit            mon_en = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (im_wr_en === 1'b1) begin
        im_cnt++;
        check("write_exclusive", {63'b0, dm_wr_en}, 64'd0);
        if (im_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL im_unexpected: write addr 0x%0h data 0x%0h, none expected",
                   im_wr_addr, wr_data);
        end else begin
          exp_w = im_q.pop_front();
          check("im_addr", {54'b0, im_wr_addr}, {54'b0, exp_w.addr});
          check("im_data", {32'b0, wr_data}, {32'b0, exp_w.data});
        end
      end
      if (dm_wr_en === 1'b1) begin
        dm_cnt++;
        if (dm_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dm_unexpected: write addr 0x%0h, none expected", dm_wr_addr);
        end else begin
          exp_a = dm_q.pop_front();
          check("dm_addr", {54'b0, dm_wr_addr}, {54'b0, exp_a});
          check("dm_data", {32'b0, wr_data}, 64'd0);
        end
      end
      if (pc_reset === 1'b1) begin
        pc_cnt++;
        check("handoff_stall", {63'b0, cpu_stall}, 64'd1);
        check("handoff_bios_sel", {63'b0, bios_sel}, 64'd0);
      end
    end
  end

  task automatic push_im(input int a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    im_q.push_back(w);
  endtask

  task automatic push_clear();
    for (int i = 0; i < CLR; i++) dm_q.push_back(AW'(i));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_sysrun(input string name, input int budget);
    int n = 0;
    while (!(bios_sel === 1'b0 && cpu_stall === 1'b0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_bios_sel"}, {63'b0, bios_sel}, 64'd0);
    check({name, "_stall"}, {63'b0, cpu_stall}, 64'd0);
    check({name, "_busy"}, {63'b0, busy}, 64'd0);
    check({name, "_im_q_drained"}, 64'(im_q.size()), 64'd0);
    check({name, "_dm_q_drained"}, 64'(dm_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_im, base_dm, base_pc, n;
    reset = 1'b1;
    start = 1'b0;
    inj_v = 1'b0;
    inj_d = '0;
    for (int i = 0; i < 1024; i++) hd_mem[i] = '0;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1: idle after reset
    repeat (10) @(negedge clock);
    check("t1_bios_sel", {63'b0, bios_sel}, 64'd1);
    check("t1_stall", {63'b0, cpu_stall}, 64'd0);
    check("t1_busy", {63'b0, busy}, 64'd0);
    check("t1_boot_err", {63'b0, boot_err}, 64'd0);
    check("t1_hd_rd_en", {63'b0, hd_rd_en}, 64'd0);

    // 6a: stray HD valids while in BIOS_RUN
    inj_d = 32'h1234_5678;
    inj_v = 1'b1;
    repeat (2) @(negedge clock);
    inj_v = 1'b0;
    @(negedge clock);
    check("t6a_bios_sel", {63'b0, bios_sel}, 64'd1);
    check("t6a_busy", {63'b0, busy}, 64'd0);
    check("t6a_hd_rd_en", {63'b0, hd_rd_en}, 64'd0);

    // 2: short image terminated by a zero word
    hd_respond = 1'b1;
    hd_mem[0] = 32'd5;
    hd_mem[1] = 32'd7;
    hd_mem[2] = 32'd9;
    hd_mem[3] = 32'd0;
    push_im(0, 32'd5);
    push_im(1, 32'd7);
    push_im(2, 32'd9);
    push_clear();
    base_im = im_cnt;
    base_dm = dm_cnt;
    base_pc = pc_cnt;
    pulse_start();
    check("t2_req_stall", {63'b0, cpu_stall}, 64'd1);
    check("t2_req_rd_en", {63'b0, hd_rd_en}, 64'd1);
    check("t2_req_addr", {54'b0, hd_addr}, 64'd0);
    check("t2_req_busy", {63'b0, busy}, 64'd1);
    wait_sysrun("t2", 200);
    check("t2_im_writes", 64'(im_cnt - base_im), 64'd3);
    check("t2_dm_writes", 64'(dm_cnt - base_dm), 64'(CLR));
    check("t2_pc_reset_pulses", 64'(pc_cnt - base_pc), 64'd1);

    // 6b: start ignored in SYS_RUN
    base_pc = pc_cnt;
    pulse_start();
    repeat (3) @(negedge clock);
    check("t6b_bios_sel", {63'b0, bios_sel}, 64'd0);
    check("t6b_stall", {63'b0, cpu_stall}, 64'd0);
    check("t6b_hd_rd_en", {63'b0, hd_rd_en}, 64'd0);
    check("t6b_pc_reset", 64'(pc_cnt - base_pc), 64'd0);

    // 3: full-length image with no terminator
    do_reset();
    for (int i = 0; i < 1024; i++) hd_mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < COPY; i++) push_im(i, 32'hFFFF_FFFF);
    push_clear();
    base_im = im_cnt;
    base_dm = dm_cnt;
    pulse_start();
    wait_sysrun("t3", 1500);
    check("t3_im_writes", 64'(im_cnt - base_im), 64'(COPY));
    check("t3_dm_writes", 64'(dm_cnt - base_dm), 64'(CLR));

    // 4: HD never answers
    do_reset();
    hd_respond = 1'b0;
    base_im = im_cnt;
    pulse_start();
    n = 0;
    while (boot_err !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("t4_timeout_cycles", 64'(n), 64'(TMO + 1));
    check("t4_stall", {63'b0, cpu_stall}, 64'd1);
    check("t4_bios_sel", {63'b0, bios_sel}, 64'd1);
    check("t4_busy", {63'b0, busy}, 64'd0);
    repeat (5) @(negedge clock);
    check("t4_boot_err_sticky", {63'b0, boot_err}, 64'd1);
    check("t4_no_im_write", 64'(im_cnt - base_im), 64'd0);

    // 5: reset in the middle of the copy, then restart
    do_reset();
    check("t5_err_cleared", {63'b0, boot_err}, 64'd0);
    hd_respond = 1'b1;
    for (int i = 0; i < 5; i++) hd_mem[i] = DW'(11 + i);
    hd_mem[5] = 32'd0;
    for (int i = 0; i < 3; i++) push_im(i, DW'(11 + i));
    base_im = im_cnt;
    pulse_start();
    n = 0;
    while (im_cnt < base_im + 3 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (hd_rd_en !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("t5_word3_addr", {54'b0, hd_addr}, 64'd3);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_bios_sel", {63'b0, bios_sel}, 64'd1);
    check("t5_rst_stall", {63'b0, cpu_stall}, 64'd0);
    check("t5_rst_hd_rd_en", {63'b0, hd_rd_en}, 64'd0);
    check("t5_rst_hd_addr", {54'b0, hd_addr}, 64'd0);
    check("t5_rst_busy", {63'b0, busy}, 64'd0);
    check("t5_rst_pc_reset", {63'b0, pc_reset}, 64'd0);
    check("t5_rst_im_wr_en", {63'b0, im_wr_en}, 64'd0);
    check("t5_rst_dm_wr_en", {63'b0, dm_wr_en}, 64'd0);
    check("t5_rst_im_addr", {54'b0, im_wr_addr}, 64'd0);
    check("t5_rst_wr_data", {32'b0, wr_data}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push_im(i, DW'(11 + i));
    push_clear();
    base_im = im_cnt;
    pulse_start();
    check("t5_restart_addr", {54'b0, hd_addr}, 64'd0);
    wait_sysrun("t5", 200);
    check("t5_im_writes", 64'(im_cnt - base_im), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
